// File: rtl/calc_pkg.sv
// Codes shared between the keypad encoder and the calculator ALU, plus the
// keypad scanner state type and small row-pattern helpers.
package calc_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;

  localparam logic [3:0] NUM_NONE = 4'hF;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEBOUNCE,
    KP_EMIT,
    KP_RELEASE
  } kp_state_e;

  // True when exactly one active-low row is pulled down.
  function automatic logic single_low(input logic [3:0] rows);
    return rows inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational decode of a (row, col) keypad position into calculator codes.
module keypad_keymap
  import calc_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] num,
  output logic [2:0] op,
  output logic       is_eq,
  output logic       is_clr
);

  // NOTE: every output gets a default before any branch, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    num    = NUM_NONE;
    op     = OP_NONE;
    is_eq  = 1'b0;
    is_clr = 1'b0;
    if (col == 2'd3) begin
      // Operator column runs ADD, SUB, MUL, DIV top to bottom.
      op = OP_ADD + {1'b0, row};
    end else if (row != 2'd3) begin
      num = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end else begin
      case (col)
        2'd0:    is_clr = 1'b1;
        2'd1:    num    = 4'd0;
        default: is_eq  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner: column scan, press/release debounce and a
// single registered key event per press in the calculator's button encoding.
module keypad_encoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] button_num,
  output logic [2:0] button_op,
  output logic       equal,
  output logic       clr_key,
  output logic       key_valid
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

  kp_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       row_cap_q, row_cap_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] deb_inc;
  logic [3:0]       col_out_q, col_out_d;
  logic [3:0]       num_q, num_d;
  logic [2:0]       op_q, op_d;
  logic             eq_q, eq_d;
  logic             clr_q, clr_d;
  logic             valid_q, valid_d;
  logic             sample;
  logic             emit_load;

  logic [3:0] map_num;
  logic [2:0] map_op;
  logic       map_eq;
  logic       map_clr;

  // Column is held whenever an event is loaded, so the live row pattern
  // always names the captured key.
  keypad_keymap u_keymap (
    .row    (low_index(row_in)),
    .col    (col_q),
    .num    (map_num),
    .op     (map_op),
    .is_eq  (map_eq),
    .is_clr (map_clr)
  );

  assign sample  = (div_q == DIV_LAST);
  assign deb_inc = deb_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    div_d     = sample ? '0 : div_q + 1'b1;
    col_d     = col_q;
    row_cap_d = row_cap_q;
    deb_d     = deb_q;
    emit_load = 1'b0;

    case (state_q)
      KP_SCAN: begin
        if (sample) begin
          if (single_low(row_in)) begin
            row_cap_d = row_in;
            deb_d     = DEB_W'(1);
            if (DEB_LAST == DEB_W'(1)) begin
              state_d   = KP_EMIT;
              emit_load = 1'b1;
            end else begin
              state_d = KP_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      KP_DEBOUNCE: begin
        if (sample) begin
          if (row_in == row_cap_q) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_LAST) begin
              state_d   = KP_EMIT;
              emit_load = 1'b1;
            end
          end else begin
            state_d = KP_SCAN;
            col_d   = col_q + 2'd1;
            deb_d   = '0;
          end
        end
      end
      KP_EMIT: begin
        state_d = KP_RELEASE;
        deb_d   = '0;
      end
      default: begin
        // Release counter reuses deb_q: consecutive all-open samples.
        if (sample) begin
          if (row_in == 4'hF) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_LAST) begin
              state_d = KP_SCAN;
              col_d   = 2'd0;
              deb_d   = '0;
            end
          end else begin
            deb_d = '0;
          end
        end
      end
    endcase

    col_out_d = ~(4'b0001 << col_d);
    num_d     = emit_load ? map_num : NUM_NONE;
    op_d      = emit_load ? map_op  : OP_NONE;
    eq_d      = emit_load & map_eq;
    clr_d     = emit_load & map_clr;
    valid_d   = emit_load;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= KP_SCAN;
      div_q     <= '0;
      col_q     <= 2'd0;
      row_cap_q <= 4'hF;
      deb_q     <= '0;
      col_out_q <= 4'b1110;
      num_q     <= NUM_NONE;
      op_q      <= OP_NONE;
      eq_q      <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_q     <= col_d;
      row_cap_q <= row_cap_d;
      deb_q     <= deb_d;
      col_out_q <= col_out_d;
      num_q     <= num_d;
      op_q      <= op_d;
      eq_q      <= eq_d;
      clr_q     <= clr_d;
      valid_q   <= valid_d;
    end
  end

  assign col_out    = col_out_q;
  assign button_num = num_q;
  assign button_op  = op_q;
  assign equal      = eq_q;
  assign clr_key    = clr_q;
  assign key_valid  = valid_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Keypad encoder bench: physical keypad model, behavioural scanner model with
// per-cycle compare, directed scenarios, randomized presses and a calculator.
module tb_keypad_encoder;
  import calc_pkg::*;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] button_num;
  logic [2:0] button_op;
  logic       equal;
  logic       clr_key;
  logic       key_valid;
  logic [15:0] pressed = '0;  // bit r*4+c closed

  always #5 clk = ~clk;

  // A closed key pulls its row low when its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk        (clk),
    .clear      (clear),
    .row_in     (row_in),
    .col_out    (col_out),
    .button_num (button_num),
    .button_op  (button_op),
    .equal      (equal),
    .clr_key    (clr_key),
    .key_valid  (key_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string keys = "123+456-789*C0=/";
  int  m_div, m_col, m_match, m_row, m_quiet, m_n, m_r, m_ev;
  bit  m_held, m_emitting, m_smp;
  bit  m_live = 1'b0;

  function automatic int keys_low(input int col, output int row);
    int n;
    n = 0;
    row = 0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r*4+col]) begin
        n++;
        row = r;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (clear) begin
      m_div = 0; m_col = 0; m_match = 0; m_quiet = 0;
      m_held = 0; m_emitting = 0; m_live = 1;
    end else if (m_live) begin
      m_smp = (m_div == SD - 1);
      m_div = (m_div + 1) % SD;
      m_n   = keys_low(m_col, m_r);
      if (m_emitting) begin
        m_emitting = 0; m_held = 1; m_quiet = 0; m_match = 0;
      end else if (m_smp) begin
        if (m_held) begin
          if (m_n == 0) m_quiet++; else m_quiet = 0;
          if (m_quiet == DB) begin m_held = 0; m_col = 0; end
        end else if (m_match == 0) begin
          if (m_n == 1) begin
            m_row = m_r; m_match = 1;
            if (m_match == DB) m_emitting = 1;
          end else m_col = (m_col + 1) % 4;
        end else if (m_n == 1 && m_r == m_row) begin
          m_match++;
          if (m_match == DB) m_emitting = 1;
        end else begin
          m_match = 0; m_col = (m_col + 1) % 4;
        end
      end
    end
    m_ev = m_emitting ? m_row * 4 + m_col : -1;
  end

  int  e_num, e_op, e_eq, e_clr, e_v;
  byte ch;

  always @(negedge clk) begin
    if (m_live) begin
      e_num = 15; e_op = 0; e_eq = 0; e_clr = 0; e_v = 0;
      if (m_ev >= 0) begin
        ch  = keys[m_ev];
        e_v = 1;
        if (ch >= "0" && ch <= "9") e_num = ch - "0";
        else case (ch)
          "+": e_op = 1;
          "-": e_op = 2;
          "*": e_op = 3;
          "/": e_op = 4;
          "=": e_eq = 1;
          default: e_clr = 1;
        endcase
      end
      check("col_out",    col_out,    15 ^ (1 << m_col));
      check("button_num", button_num, e_num);
      check("button_op",  button_op,  e_op);
      check("equal",      equal,      e_eq);
      check("clr_key",    clr_key,    e_clr);
      check("key_valid",  key_valid,  e_v);
    end
  end

  // ---------------- event observer + calculator ----------------
  int ev_cnt = 0, eq_cnt = 0, clr_cnt = 0;
  int last_num = 15, last_op = 0;
  int calc_acc = 0, calc_cur = 0, calc_op = 0, calc_result = 0;

  always @(negedge clk) begin
    if (key_valid) begin
      ev_cnt++;
      last_num = button_num;
      last_op  = button_op;
      if (equal) begin
        eq_cnt++;
        case (calc_op)
          1: calc_result = calc_acc + calc_cur;
          2: calc_result = calc_acc - calc_cur;
          3: calc_result = calc_acc * calc_cur;
          4: calc_result = (calc_cur != 0) ? calc_acc / calc_cur : 0;
          default: calc_result = calc_cur;
        endcase
      end else if (clr_key) begin
        clr_cnt++;
        calc_acc = 0; calc_cur = 0; calc_op = 0; calc_result = 0;
      end else if (button_op != OP_NONE) begin
        calc_acc = calc_cur; calc_op = button_op; calc_cur = 0;
      end else begin
        calc_cur = calc_cur * 10 + button_num;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_events(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (ev_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, ev_cnt, target);
  endtask

  task automatic tap(input int key_bit, input string name);
    int e0;
    e0 = ev_cnt;
    pressed[key_bit] = 1'b1;
    wait_events(e0 + 1, 300, name);
    cycles(5);
    pressed = '0;
    cycles(40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, c0, q0, steps, k;
    logic [3:0] prev;

    @(negedge clk);
    check("rst col_out", col_out, 4'b1110);
    check("rst num", button_num, 4'hF);
    check("rst op", button_op, 0);
    check("rst equal", equal, 0);
    check("rst clr_key", clr_key, 0);
    check("rst valid", key_valid, 0);
    clear = 1'b0;
    cycles(3);

    // '5' held: one event, none while held, none after a short release.
    e0 = ev_cnt;
    pressed[5] = 1'b1;
    wait_events(e0 + 1, 200, "press 5");
    check("press 5 num", last_num, 5);
    cycles(150);
    check("hold 5 single", ev_cnt, e0 + 1);
    pressed = '0;
    cycles(5);
    pressed[5] = 1'b1;
    cycles(100);
    check("short release no event", ev_cnt, e0 + 1);
    pressed = '0;
    cycles(40);
    pressed[5] = 1'b1;
    wait_events(e0 + 2, 200, "repress 5");
    check("repress 5 num", last_num, 5);
    pressed = '0;
    cycles(40);

    // '+' bounces, then stays closed.
    e0 = ev_cnt;
    pressed[3] = 1'b1; cycles(SD);
    pressed[3] = 1'b0; cycles(SD);
    pressed[3] = 1'b1;
    wait_events(e0 + 1, 200, "plus event");
    check("plus op", last_op, 1);
    check("plus num", last_num, 15);
    cycles(60);
    check("plus single", ev_cnt, e0 + 1);
    pressed = '0;
    cycles(40);

    // 'C' then '='.
    c0 = clr_cnt; q0 = eq_cnt;
    tap(12, "press C");
    check("C pulses", clr_cnt, c0 + 1);
    tap(14, "press =");
    check("= pulses", eq_cnt, q0 + 1);
    check("= num idle", last_num, 15);
    check("= op idle", last_op, 0);

    // Two rows low on c0: no event, columns keep rotating.
    e0 = ev_cnt;
    pressed[0] = 1'b1; pressed[8] = 1'b1;
    prev = col_out; steps = 0;
    for (int i = 0; i < 12 * SD; i++) begin
      @(negedge clk);
      if (col_out != prev) begin
        check("rotation", col_out, {prev[2:0], prev[3]});
        steps++;
        prev = col_out;
      end
    end
    check("rotation steps", steps, 12);
    check("ghost no event", ev_cnt, e0);
    pressed = '0;
    cycles(10);

    // clear during DEBOUNCE of '7'.
    e0 = ev_cnt;
    pressed[8] = 1'b1;
    k = 0;
    while (!(m_match == 1 && !m_held) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach debounce 7", int'(k < 100), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear col_out", col_out, 4'b1110);
    check("clear no event", key_valid, 0);
    check("clear suppressed", ev_cnt, e0);
    wait_events(e0 + 1, 200, "press 7 after clear");
    check("press 7 num", last_num, 7);
    pressed = '0;
    cycles(40);

    // 3 * 4 = into the calculator.
    tap(12, "calc C");
    tap(2,  "calc 3");
    tap(11, "calc *");
    tap(4,  "calc 4");
    tap(14, "calc =");
    check("calc result", calc_result, 12);

    // Random presses, chords, bounces and occasional clears.
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      pressed = '0;
      pressed[$urandom_range(15, 0)] = 1'b1;
      if ($urandom_range(3, 0) == 0) pressed[$urandom_range(15, 0)] = 1'b1;
      cycles($urandom_range(60, 1));
      if ($urandom_range(9, 0) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
      pressed = '0;
      cycles($urandom_range(50, 1));
    end
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
